// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: transmit-side word buffer feeding the spi_master FIFO read port.
// Host pushes with wr_en/wr_data; the master pulls with fifo_req_data and gets
// the word one cycle later on fifo_din with a single-cycle fifo_din_valid pulse.
// Optional feature macro: SPI_TX_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow.
module spi_tx_fifo #(
   parameter int unsigned data_width_g = 8,
   parameter int unsigned depth_g      = 16,
   parameter int unsigned log_depth_g  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [data_width_g-1:0] wr_data,
   input  logic                    flush,
   output logic                    full,
   output logic [log_depth_g:0]    used,
   input  logic                    fifo_req_data,
   output logic [data_width_g-1:0] fifo_din,
   output logic                    fifo_din_valid,
`ifdef SPI_TX_FIFO_ERR_FLAGS_EN
   output logic                    overflow,
   output logic                    underflow,
`endif
   output logic                    fifo_empty
);

   localparam logic [log_depth_g:0]   DepthCount = (log_depth_g + 1)'(depth_g);
   localparam logic [log_depth_g:0]   CountOne   = (log_depth_g + 1)'(1);
   localparam logic [log_depth_g-1:0] PtrOne     = log_depth_g'(1);

   logic [data_width_g-1:0] mem [depth_g];
   logic [log_depth_g-1:0]  wr_ptr_q, rd_ptr_q;
   logic [log_depth_g:0]    count_q, count_d;
   logic [data_width_g-1:0] din_q;
   logic                    valid_q, full_q, empty_q;
   logic                    wr_acc, rd_acc;

   // Acceptance uses pre-edge flags; flush suppresses both sides.
   always_comb begin
      wr_acc  = wr_en & ~full_q & ~flush;
      rd_acc  = fifo_req_data & ~empty_q & ~flush;
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else begin
         unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
         endcase
      end
   end

   // Storage array is not reset; contents are only meaningful below count.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   // Pointers, count, read data and status flags; flags follow next-state count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         din_q    <= '0;
         valid_q  <= 1'b0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         valid_q <= rd_acc;
         count_q <= count_d;
         full_q  <= (count_d == DepthCount);
         empty_q <= (count_d == '0);
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (wr_acc) begin
               wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (rd_acc) begin
               rd_ptr_q <= rd_ptr_q + PtrOne;
               din_q    <= mem[rd_ptr_q];
            end
         end
      end
   end

`ifdef SPI_TX_FIFO_ERR_FLAGS_EN
   logic overflow_q, underflow_q;

   // Sticky error flags: set on dropped write / ignored request, cleared by flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (flush) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_en && full_q) begin
            overflow_q <= 1'b1;
         end
         if (fifo_req_data && empty_q) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

   assign full           = full_q;
   assign fifo_empty     = empty_q;
   assign used           = count_q;
   assign fifo_din       = din_q;
   assign fifo_din_valid = valid_q;

endmodule

// File: doc/spi_tx_fifo.md
# spi_tx_fifo

Transmit-side buffer that feeds the SPI master's FIFO read port. The host side pushes words with a simple write strobe. The SPI master pulls words with `fifo_req_data` and receives each one a cycle later on `fifo_din`/`fifo_din_valid`. `fifo_empty` tells the master when a burst has drained. The block sits directly upstream of `spi_master` and connects 1:1 to its `fifo_*` ports.

## Interface
Parameters:
- `data_width_g`, 8 — word width; must equal the `spi_master` data width.
- `depth_g`, 16 — number of entries; power of two, ≥ 2.
- `log_depth_g`, 4 — log2(`depth_g`); sizes the pointers.

Ports:
- `clk`  in  1  — system clock; all logic is rising-edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `wr_en`  in  1  — push `wr_data` this cycle.
- `wr_data`  in  `data_width_g`  — word to push.
- `flush`  in  1  — synchronous clear of contents and flags.
- `full`  out  1  — no free entry.
- `used`  out  `log_depth_g`+1  — current occupancy, 0..`depth_g`.
- `fifo_req_data`  in  1  — read request from `spi_master`.
- `fifo_din`  out  `data_width_g`  — read data to `spi_master`.
- `fifo_din_valid`  out  1  — `fifo_din` valid; 1-cycle pulse.
- `fifo_empty`  out  1  — no stored entry.
- `overflow`  out  1  — sticky flag: a write was dropped. Present only with `SPI_TX_FIFO_ERR_FLAGS_EN`.
- `underflow`  out  1  — sticky flag: a request was ignored. Present only with `SPI_TX_FIFO_ERR_FLAGS_EN`.

## Operation
- Storage: circular RAM of `depth_g` words. Write pointer, read pointer and count are all registered. Pointers wrap modulo `depth_g` by natural `log_depth_g`-bit overflow.
- Write: accepted when `wr_en`=1 and `full`=0 at the clock edge. The word is stored at the write pointer, and the write pointer increments.
- Read: accepted when `fifo_req_data`=1 and `fifo_empty`=0 at the clock edge. The entry at the read pointer is registered onto `fifo_din`, `fifo_din_valid` is set for one cycle, and the read pointer increments.
- Flags are evaluated on the pre-edge state.
  - A write while `full`=1 is dropped, even if a read is accepted in the same cycle.
  - A request while `fifo_empty`=1 is ignored, even if a write is accepted in the same cycle. No valid pulse is produced.
- Count update:
  - +1 on an accepted write only.
  - −1 on an accepted read only.
  - Unchanged when both are accepted, or when neither is.
- Status outputs are all registered and derived from the next-state count:
  - `full` = (count == `depth_g`).
  - `fifo_empty` = (count == 0).
  - `used` = count.
- `fifo_din` holds the last value read between requests.
- `flush` clears pointers, count and sticky flags, and suppresses any read or write in the same cycle. After the edge, `fifo_empty`=1, `full`=0 and `used`=0. `fifo_din` keeps its value.
- Reset values: `fifo_din`=0, `fifo_din_valid`=0, `fifo_empty`=1, `full`=0, `used`=0, `overflow`=0, `underflow`=0. Pointers are 0.
- Reset during a transfer discards all contents. A request pending at the reset edge produces no valid pulse.

## Timing
- Read latency: request at edge N produces `fifo_din_valid`=1 and the data during cycle N→N+1.
- Back-to-back requests are supported. Requests on N and N+1 give valid pulses on consecutive cycles.
- Write-to-read latency: a word written at edge N raises `fifo_empty`=0 after edge N. It can first be requested at edge N+1, and its data appears after edge N+1.
- `full` and `fifo_empty` reflect the post-edge state with no extra cycle of lag.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- Macro: `SPI_TX_FIFO_ERR_FLAGS_EN`.
- Defined:
  - `overflow` and `underflow` ports exist.
  - `overflow` sets on any dropped write.
  - `underflow` sets on any ignored request.
  - Both clear only on `rst` or `flush`.
- Undefined:
  - Both ports and their logic are absent.
  - Dropped writes and ignored requests are silent.
  - All other behaviour is identical.

## Test plan
- Reset, then write 0x11, 0x22, 0x33; request 3 times back-to-back → `fifo_din` = 0x11, 0x22, 0x33 on three consecutive valid pulses. `fifo_empty`=1 after the third request; `used` goes 3→0.
- Write 16 words 0x00..0x0F (`depth_g`=16), then write 0xAA → `full`=1, `used`=16, 0xAA dropped, `overflow`=1. Drain all 16 → data 0x00..0x0F in order.
- Fill 15 words, then issue simultaneous write and request for 20 cycles → `used` stays 15 and data stays in order across the pointer wrap.
- Empty FIFO: request and write 0x5A in the same cycle → no valid pulse, `underflow`=1, `used`=1. Next request returns 0x5A.
- Write 4 words, then `flush` concurrently with a request → no valid pulse, `used`=0, `fifo_empty`=1, flags cleared.
- Write 5 words, request once, then assert `rst` low asynchronously mid-cycle → outputs reach reset values immediately, without waiting for a clock edge. The next request after release gives no valid pulse.
